multicycle_control: RTL

- Multi-cycle successor to the single-cycle opcode/funct decoder.
- Sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and drives datapath control per state.
- Waits on a unified memory ready handshake, with a parametrised watchdog timeout.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: per-state control sequencer for a shared-memory multi-cycle MIPS datapath,
// with a memory-ready watchdog that traps into an absorbing FAULT state.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
        EXEC_I, ALU_WB, BRANCH, JUMP, JAL, JR, FAULT, ILLEGAL
    } state_t;
    localparam logic [TO_W-1:0] TO = TO_W'(MEM_TIMEOUT);
    state_t state_q, state_d;
    logic [5:0] op_q, op_d;
    logic is_r_q, is_r_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic waiting, timeout;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            is_r_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            is_r_q  <= is_r_d;
            wd_q    <= wd_d;
        end
    end
    always_comb begin
        waiting = state_q inside {FETCH, MEM_RD, MEM_WR};
        timeout = MEM_TIMEOUT != 0 && waiting && !mem_ready && wd_q == TO;
        op_d    = state_q == DECODE ? opcode : op_q;
        is_r_d  = state_q == DECODE ? opcode == 6'b000000 : is_r_q;
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == 6'b000000)
                    state_d = funct == 6'b001000 ? JR : EXEC_R;
                else if (opcode == 6'b100011 || opcode == 6'b101011)
                    state_d = MEM_ADDR;
                else if (opcode == 6'b000100 || opcode == 6'b000101)
                    state_d = BRANCH;
                else if (opcode == 6'b000010)
                    state_d = JUMP;
                else if (opcode == 6'b000011)
                    state_d = JAL;
                else if (opcode >= 6'b001000 && opcode <= 6'b001101)
                    state_d = EXEC_I;
                else
                    state_d = ILLEGAL;
            end
            MEM_ADDR: state_d = op_q == 6'b100011 ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            EXEC_R:   state_d = ALU_WB;
            EXEC_I:   state_d = ALU_WB;
            FAULT:    state_d = FAULT;
            default:  state_d = FETCH;
        endcase
        if (timeout)
            state_d = FAULT;
        // any state change clears the count, so each wait state starts from zero
        wd_d = state_d != state_q ? '0 :
               (waiting && !mem_ready && wd_q != '1) ? wd_q + 1'b1 : wd_q;
    end
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        retire        = 1'b0;
        illegal_op    = 1'b0;
        mem_fault     = 1'b0;
        state         = state_q;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:   alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = is_r_q ? 2'b01 : 2'b00;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = op_q == 6'b000101;
                retire        = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                retire     = 1'b1;
            end
            JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                retire    = 1'b1;
            end
            ILLEGAL:  illegal_op = 1'b1;
            FAULT:    mem_fault = 1'b1;
            default: ;
        endcase
    end
endmodule
